// File: rtl/ext_adc_pkg.sv
// ext_adc_pkg: shared constants and state encoding
// for the external serial ADC front end.
package ext_adc_pkg;

  localparam int ValueWidth    = 16;
  localparam int DefClkDiv     = 4;
  localparam int DefConvCycles = 8;
  localparam int DefDataBits   = 16;

  typedef enum logic [2:0] {
    stIdle        = 3'd0,
    stConvWait    = 3'd1,
    stShift       = 3'd2,
    stDone        = 3'd3,
    stWaitRelease = 3'd4
  } state_e;

endpackage

// File: rtl/ext_adc_spi_frontend_timer.sv
// spi_phase_timer: 8-bit loadable down-counter; tc flags
// the last cycle of a loaded interval of N cycles.
module spi_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       tc
);

  logic [7:0] count;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign tc = (count == 8'd1);

endmodule

// File: rtl/ext_adc_spi_frontend.sv
// ext_adc_spi_frontend: answers the convert handshake
// by clocking a serial ADC result in MSB first.
module ext_adc_spi_frontend
  import ext_adc_pkg::*;
#(
  parameter int ClkDiv     = DefClkDiv,
  parameter int ConvCycles = DefConvCycles,
  parameter int DataBits   = DefDataBits
) (
  input  logic                  Reset_n_i,
  input  logic                  Clk_i,
  input  logic                  AdcDoConvert_i,
  output logic                  AdcConvComplete_o,
  output logic [ValueWidth-1:0] AdcValue_o,
  output logic                  AdcCS_n_o,
  output logic                  AdcSCLK_o,
  input  logic                  AdcMISO_i
);

  state_e state_q, state_d;
  logic [4:0] bit_q, bit_d;
  logic [ValueWidth-1:0] shift_q, shift_d;
  logic [ValueWidth-1:0] value_d;
  logic cs_d, sclk_d, done_d;
  logic tmr_load, tmr_tc;
  logic [7:0] tmr_val;

  spi_phase_timer u_timer (
    .clk        (Clk_i),
    .rst_n      (Reset_n_i),
    .load       (tmr_load),
    .load_value (tmr_val),
    .tc         (tmr_tc)
  );

  // Next state and registered-output values.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    value_d  = AdcValue_o;
    cs_d     = 1'b1;
    sclk_d   = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = ClkDiv[7:0];
    unique case (state_q)
      stIdle: begin
        if (AdcDoConvert_i) begin
          state_d  = stConvWait;
          tmr_load = 1'b1;
          tmr_val  = ConvCycles[7:0];
          shift_d  = '0;
          cs_d     = 1'b0;
        end
      end
      stConvWait: begin
        if (!AdcDoConvert_i) begin
          state_d = stIdle;
        end else begin
          cs_d = 1'b0;
          if (tmr_tc) begin
            state_d  = stShift;
            tmr_load = 1'b1;
            bit_d    = DataBits[4:0];
          end
        end
      end
      stShift: begin
        if (!AdcDoConvert_i) begin
          state_d = stIdle;
        end else begin
          cs_d   = 1'b0;
          sclk_d = AdcSCLK_o;
          if (tmr_tc) begin
            tmr_load = 1'b1;
            sclk_d   = ~AdcSCLK_o;
            if (AdcSCLK_o) begin
              shift_d = {shift_q[ValueWidth-2:0], AdcMISO_i};
              bit_d   = bit_q - 5'd1;
              if (bit_q == 5'd1) begin
                state_d = stDone;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                done_d  = 1'b1;
                value_d = shift_d;
              end
            end
          end
        end
      end
      stDone: begin
        state_d = stWaitRelease;
      end
      stWaitRelease: begin
        if (!AdcDoConvert_i) begin
          state_d = stIdle;
        end
      end
      default: begin
        state_d = stIdle;
      end
    endcase
  end

  // State, counters and all outputs are registered.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q           <= stIdle;
      bit_q             <= 5'd0;
      shift_q           <= '0;
      AdcValue_o        <= '0;
      AdcCS_n_o         <= 1'b1;
      AdcSCLK_o         <= 1'b0;
      AdcConvComplete_o <= 1'b0;
    end else begin
      state_q           <= state_d;
      bit_q             <= bit_d;
      shift_q           <= shift_d;
      AdcValue_o        <= value_d;
      AdcCS_n_o         <= cs_d;
      AdcSCLK_o         <= sclk_d;
      AdcConvComplete_o <= done_d;
    end
  end

endmodule

// File: tb/tb_ext_adc_spi_frontend.sv
// tb_ext_adc_spi_frontend: directed checks of the
// convert handshake, SPI timing, abort and reset.
module tb_ext_adc_spi_frontend;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic miso;
  logic done, cs_n, sclk;
  logic [15:0] value;

  logic req2 = 1'b0;
  logic miso2 = 1'b0;
  logic done2, cs2, sclk2;
  logic [15:0] value2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ext_adc_spi_frontend u_dut (
    .Reset_n_i         (rst_n),
    .Clk_i             (clk),
    .AdcDoConvert_i    (req),
    .AdcConvComplete_o (done),
    .AdcValue_o        (value),
    .AdcCS_n_o         (cs_n),
    .AdcSCLK_o         (sclk),
    .AdcMISO_i         (miso)
  );

  ext_adc_spi_frontend #(
    .ClkDiv     (1),
    .ConvCycles (1),
    .DataBits   (12)
  ) u_dut2 (
    .Reset_n_i         (rst_n),
    .Clk_i             (clk),
    .AdcDoConvert_i    (req2),
    .AdcConvComplete_o (done2),
    .AdcValue_o        (value2),
    .AdcCS_n_o         (cs2),
    .AdcSCLK_o         (sclk2),
    .AdcMISO_i         (miso2)
  );

  // ADC model: MSB on CS fall, next bit after each SCLK fall.
  logic [15:0] pat = 16'h0000;
  logic [15:0] pat_sh;
  int falls = 0;
  int rises = 0;
  int cs_falls = 0;
  logic cs_prev = 1'b1;
  logic sclk_prev = 1'b0;

  always @(cs_n or sclk) begin
    if (cs_prev && !cs_n) begin
      falls = 0;
      rises = 0;
      cs_falls = cs_falls + 1;
    end
    if (sclk_prev && !sclk) falls = falls + 1;
    if (!sclk_prev && sclk) rises = rises + 1;
    cs_prev = cs_n;
    sclk_prev = sclk;
  end

  assign pat_sh = pat << falls;
  assign miso = pat_sh[15];

  int dones = 0;
  int dones2 = 0;
  always @(posedge clk) begin
    if (done) dones <= dones + 1;
    if (done2) dones2 <= dones2 + 1;
  end

  task automatic check(input string name,
                       input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Request already high: count edges until Complete.
  task automatic wait_done(output int lat, output int cs_low);
    lat = -1;
    cs_low = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!cs_n) cs_low++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_conv(input logic [15:0] p,
                          output int lat, output int cs_low);
    pat = p;
    @(negedge clk);
    req = 1'b1;
    wait_done(lat, cs_low);
  endtask

  typedef struct {
    logic [15:0] pat;
    logic [15:0] val;
    int lat;
    int rises;
    int cs_low;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, csl, d0, c0, n2;
    logic [15:0] b2b[3];

    vecs[0] = '{16'hA5C3, 16'hA5C3, 137, 16, 136};
    vecs[1] = '{16'h0001, 16'h0001, 137, 16, 136};
    vecs[2] = '{16'h8000, 16'h8000, 137, 16, 136};
    vecs[3] = '{16'hA5C3, 16'hA5C3, 137, 16, 136};

    repeat (3) @(negedge clk);
    check("rst_cs", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_done", done, 0);
    check("rst_value", value, 0);
    check("rst_value2", value2, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven conversions with the standard release.
    for (int i = 0; i < 4; i++) begin
      run_conv(vecs[i].pat, lat, csl);
      check("latency", lat, vecs[i].lat);
      check("value", value, vecs[i].val);
      check("sclk_rises", rises, vecs[i].rises);
      check("cs_low_cycles", csl, vecs[i].cs_low);
      req = 1'b0;
      @(negedge clk);
      check("done_width", done, 0);
      repeat (3) @(negedge clk);
    end

    // Abort at SCLK rise 5.
    pat = 16'h0F0F;
    c0 = cs_falls;
    d0 = dones;
    @(negedge clk);
    req = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (cs_falls > c0 && rises >= 5) break;
    end
    check("abort_rise", rises, 5);
    req = 1'b0;
    @(negedge clk);
    check("abort_cs", cs_n, 1);
    check("abort_sclk", sclk, 0);
    repeat (200) @(negedge clk);
    check("abort_nodone", dones - d0, 0);
    check("abort_value", value, 16'hA5C3);

    // Abort during the conversion wait.
    d0 = dones;
    @(negedge clk);
    req = 1'b1;
    repeat (3) @(negedge clk);
    check("abortw_cs_low", cs_n, 0);
    req = 1'b0;
    @(negedge clk);
    check("abortw_cs", cs_n, 1);
    repeat (20) @(negedge clk);
    check("abortw_nodone", dones - d0, 0);

    // Held request: no second conversion.
    run_conv(16'h3C5A, lat, csl);
    check("held_value", value, 16'h3C5A);
    repeat (2) @(negedge clk);
    d0 = dones;
    c0 = cs_falls;
    repeat (500) @(negedge clk);
    check("held_no_cs", cs_falls - c0, 0);
    check("held_no_done", dones - d0, 0);
    check("held_cs_high", cs_n, 1);
    req = 1'b0;
    @(negedge clk);
    run_conv(16'h6D2B, lat, csl);
    check("rearm_lat", lat, 137);
    check("rearm_value", value, 16'h6D2B);
    req = 1'b0;
    repeat (3) @(negedge clk);

    // Reduced width instance.
    miso2 = 1'b1;
    @(negedge clk);
    req2 = 1'b1;
    n2 = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done2) begin
        n2 = n;
        break;
      end
    end
    check("red_lat", n2, 26);
    check("red_value", value2, 16'h0FFF);
    req2 = 1'b0;
    miso2 = 1'b0;
    repeat (3) @(negedge clk);
    req2 = 1'b1;
    n2 = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done2) begin
        n2 = n;
        break;
      end
    end
    check("red_lat0", n2, 26);
    check("red_value0", value2, 0);
    req2 = 1'b0;

    // Reset in the middle of bit 8.
    pat = 16'hFFFF;
    c0 = cs_falls;
    @(negedge clk);
    req = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (cs_falls > c0 && rises >= 8) break;
    end
    check("rst_mid_sclk_hi", sclk, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs", cs_n, 1);
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_value", value, 0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_conv(16'h5AA5, lat, csl);
    check("post_rst_lat", lat, 137);
    check("post_rst_value", value, 16'h5AA5);
    req = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back with the standard requester.
    b2b[0] = 16'h1234;
    b2b[1] = 16'hBEEF;
    b2b[2] = 16'h8001;
    d0 = dones;
    run_conv(b2b[0], lat, csl);
    check("b2b0_lat", lat, 137);
    check("b2b0_value", value, b2b[0]);
    for (int k = 1; k < 3; k++) begin
      req = 1'b0;
      pat = b2b[k];
      @(negedge clk);
      check("b2b_done_width", done, 0);
      check("b2b_gap1", cs_n, 1);
      @(negedge clk);
      check("b2b_gap2", cs_n, 1);
      req = 1'b1;
      wait_done(lat, csl);
      check("b2b_lat", lat, 137);
      check("b2b_value", value, b2b[k]);
      check("b2b_cs_low", csl, 136);
    end
    req = 1'b0;
    @(negedge clk);
    check("b2b_done_width", done, 0);
    check("b2b_pulses", dones - d0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ext_adc_spi_frontend.md
# ext_adc_spi_frontend

Converter-side responder for the `AdcDoConvert` / `AdcConvComplete` / `AdcValue` handshake used by the sensor application FSMs.
- Accepts a level-held convert request and drives an external serial ADC over a 3-wire SPI-style link (CS_n, SCLK, MISO).
- Captures the conversion result MSB first, then presents it with a one-cycle completion pulse.
- Sits between the reconfigurable application module and the chip pins; it replaces the direct ADC hookup.

## Interface
- `ClkDiv`, default 4: SCLK half-period in `Clk_i` cycles; legal range 1..255.
- `ConvCycles`, default 8: cycles CS_n is held low before the first SCLK edge (ADC conversion time); legal range 1..255.
- `DataBits`, default 16: bits shifted per conversion; legal range 1..16.

Ports:
- `Reset_n_i` in 1: asynchronous reset, active low.
- `Clk_i` in 1: single clock; all logic is on the rising edge.
- `AdcDoConvert_i` in 1: convert request, level, held high by the requester until the completion pulse.
- `AdcConvComplete_o` out 1: one-cycle pulse when the result is valid.
- `AdcValue_o` out 16: last result, right-aligned, upper bits zero.
- `AdcCS_n_o` out 1: ADC chip select, active low.
- `AdcSCLK_o` out 1: serial clock; idles low.
- `AdcMISO_i` in 1: serial data from the ADC.

## Operation
- All outputs are registered.
- Reset values: CS_n = 1, SCLK = 0, Complete = 0, Value = 0, state = stIdle.

State machine (stIdle, stConvWait, stShift, stDone, stWaitRelease):
- **stIdle:** if `AdcDoConvert_i` = 1, go to stConvWait and load the wait counter with ConvCycles.
- **stConvWait:** CS_n = 0, SCLK = 0. Decrement the counter; on terminal count, go to stShift and load the bit counter with DataBits.
- **stShift:** CS_n = 0.
  - Each bit is a SCLK-low phase of ClkDiv cycles followed by a SCLK-high phase of ClkDiv cycles.
  - MISO is sampled into the shift register on the Clk edge that ends the high phase (SCLK returns low).
  - After the last bit, go to stDone.
- **stDone:** CS_n = 1, SCLK = 0, Complete = 1 for exactly this cycle. `AdcValue_o` is loaded from the shift register on the edge entering stDone. Always go to stWaitRelease.
- **stWaitRelease:** go to stIdle when `AdcDoConvert_i` = 0. A request held high never triggers a second conversion.
- **Abort:** `AdcDoConvert_i` = 0 in stConvWait or stShift sends the FSM to stIdle on the next edge. CS_n goes high and SCLK goes low. No Complete pulse; `AdcValue_o` is unchanged.
- **Shift register width:** 16 bits, cleared on entry to stConvWait. Bits shift in at the LSB. Result = low DataBits bits, zero-extended.
- **Reset mid-operation:** all outputs take their reset values immediately (asynchronous). The partial result is discarded.

## Timing
- Let the request be seen high in stIdle at edge t.
- CS_n falls after edge t (cycle t+1).
- First SCLK rise occurs ConvCycles + ClkDiv cycles after the CS_n fall.
- Complete is high in cycle t + 1 + ConvCycles + 2·ClkDiv·DataBits. With defaults this is t+137.
- `AdcValue_o` is valid in the Complete cycle and holds until the next successful conversion.
- SCLK high and low phases are each exactly ClkDiv cycles. There is no SCLK edge outside stShift.
- Minimum spacing between two requests: stDone, stWaitRelease (1+ cycles), then stIdle. This gives 3 cycles from a Complete pulse to the next CS_n fall.
- With the standard requester, start drops in the cycle after Complete. CS_n stays high for at least 2 cycles between frames.

## Structure
- Shared package `ext_adc_pkg` holds:
  - the state encoding constants (3-bit);
  - the default values of ClkDiv, ConvCycles and DataBits;
  - the value width constant (16).
- Sub-module `spi_phase_timer`: an 8-bit down-counter with load and terminal-count outputs. It is used for both the ConvCycles wait and the SCLK half-phases.
- The FSM, bit counter and shift register stay in the top module.

## Test plan
- **Basic conversion:** reset, then raise the request with defaults and MISO driven from pattern 0xA5C3 MSB-first on SCLK falls. Expect Complete exactly at t+137, Value = 0xA5C3, exactly 16 SCLK rises, CS_n low 136 cycles.
- **Held request:** keep `AdcDoConvert_i` high for 500 cycles after Complete. Expect no further CS_n fall and no second Complete; drop it and raise again, then the second conversion starts 3 cycles after the first Complete at earliest.
- **Abort:** drop the request at SCLK rise 5. Expect CS_n high and SCLK low on the next cycle, no Complete, Value still 0xA5C3.
- **Reduced width:** DataBits = 12, ClkDiv = 1, ConvCycles = 1, MISO pattern 0xFFF. Expect Value = 0x0FFF and Complete at t+26.
- **Reset mid-shift:** assert `Reset_n_i` at bit 8. Expect CS_n = 1, SCLK = 0, Value = 0 asynchronously; a new request then converts normally.
- **Back-to-back with the standard requester:** run the sensor FSM handshake for 3 periods. Expect 3 Complete pulses, each 1 cycle, and each value matching its MISO pattern.
